// File: rtl/pir_conditioner.sv
`default_nettype none
//==============================================================================
// Module   : pir_conditioner
// Desc     : Three-zone PIR conditioner: 2-flop sync, debounce, per-zone holdoff
//            and single-cycle motion events. Define PIR_VOTE_EN for 2-zone voting.
// Revision : 1.0 - initial release
//==============================================================================
module pir_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int HOLDOFF_CYCLES  = 16,
    parameter int VOTE_WINDOW     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pir_sensor_1,
    input  logic       pir_sensor_2,
    input  logic       pir_sensor_3,
    input  logic       stop_alarm,
    output logic       motion_event,
    output logic [2:0] zone_mask,
    output logic [2:0] zone_active
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_HOLDOFF = 2'd3
    } zone_state_e;

    localparam logic [7:0]  c_DEB_LIMIT = DEBOUNCE_CYCLES[7:0];
    localparam logic [15:0] c_HOLD_LOAD = HOLDOFF_CYCLES[15:0];

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || HOLDOFF_CYCLES < 1 ||
        HOLDOFF_CYCLES > 65535 || VOTE_WINDOW < 1) begin : g_param_check
        $error("pir_conditioner: parameter out of legal range");
    end

    logic [2:0] pir_w;
    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic [2:0] active_w;
    logic       fire_w;
    logic       motion_event_q;
    logic [2:0] zone_mask_q;

    assign pir_w = {pir_sensor_3, pir_sensor_2, pir_sensor_1};

    // Disarm also flushes the synchronizers so qualification restarts from the raw pin.
    always_ff @(posedge clk) begin
        if (!rst_n || stop_alarm) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= pir_w;
            sync_q <= meta_q;
        end
    end

`ifdef PIR_VOTE_EN
    logic [2:0] fresh_w;
`endif

    for (genvar g = 0; g < 3; g++) begin : g_zone
        zone_state_e state_q, state_d;
        logic [7:0]  deb_q, deb_d;
        logic [15:0] hold_q, hold_d;
        logic        act_q;
        logic        consume_w;

        assign consume_w = fire_w & active_w[g];

        always_comb begin
            state_d = state_q;
            deb_d   = deb_q;
            hold_d  = hold_q;
            if (stop_alarm) begin
                state_d = ST_IDLE;
                deb_d   = '0;
                hold_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (sync_q[g]) begin
                            state_d = ST_COUNT;
                            deb_d   = 8'd1;
                        end
                    end
                    ST_COUNT: begin
                        if (!sync_q[g]) begin
                            state_d = ST_IDLE;
                            deb_d   = '0;
                        end else if (deb_q >= c_DEB_LIMIT) begin
                            state_d = ST_ACTIVE;
                            deb_d   = '0;
                        end else begin
                            deb_d = deb_q + 8'd1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (consume_w) begin
                            state_d = ST_HOLDOFF;
                            hold_d  = c_HOLD_LOAD;
                        end else if (!sync_q[g]) begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (hold_q <= 16'd1) begin
                            state_d = ST_IDLE;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q - 16'd1;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                deb_q   <= '0;
                hold_q  <= '0;
                act_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                deb_q   <= deb_d;
                hold_q  <= hold_d;
                act_q   <= (state_d == ST_ACTIVE);
            end
        end

        assign active_w[g]    = (state_q == ST_ACTIVE);
        assign zone_active[g] = act_q;

`ifdef PIR_VOTE_EN
        // Marks the first cycle a zone sits in ACTIVE: a vote needs a new arrival.
        logic fresh_q;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                fresh_q <= 1'b0;
            end else begin
                fresh_q <= (state_d == ST_ACTIVE) && (state_q != ST_ACTIVE);
            end
        end
        assign fresh_w[g] = fresh_q;
`endif
    end

`ifdef PIR_VOTE_EN
    localparam logic [15:0] c_WIN_LOAD = VOTE_WINDOW[15:0];

    logic [15:0] win_q, win_d;
    logic        two_active_w;
    logic        two_fresh_w;

    assign two_active_w = (active_w[0] & active_w[1]) | (active_w[0] & active_w[2]) |
                          (active_w[1] & active_w[2]);
    assign two_fresh_w  = (fresh_w[0] & fresh_w[1]) | (fresh_w[0] & fresh_w[2]) |
                          (fresh_w[1] & fresh_w[2]);
    assign fire_w = !stop_alarm && (|fresh_w) && two_active_w &&
                    ((win_q != 16'd0) || two_fresh_w);

    always_comb begin
        win_d = win_q;
        if (stop_alarm || fire_w) begin
            win_d = '0;
        end else if ((|fresh_w) && (win_q == 16'd0)) begin
            win_d = c_WIN_LOAD;
        end else if (win_q != 16'd0) begin
            win_d = win_q - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end
`else
    assign fire_w = !stop_alarm && (|active_w);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            motion_event_q <= 1'b0;
            zone_mask_q    <= '0;
        end else begin
            motion_event_q <= fire_w;
            if (fire_w) begin
                zone_mask_q <= active_w;
            end
        end
    end

    assign motion_event = motion_event_q;
    assign zone_mask    = zone_mask_q;

endmodule
`default_nettype wire

// File: doc/pir_conditioner.md
PIR_CONDITIONER -- requirements
Module: pir_conditioner

Parameters
REQ-001 The module SHALL provide parameter DEBOUNCE_CYCLES, default 2, giving the consecutive synchronized-high cycles required to qualify a sensor (legal range 1..255).
REQ-002 The module SHALL provide parameter HOLDOFF_CYCLES, default 16, giving the per-zone retrigger lockout after that zone contributes to an event (legal range 1..65535).
REQ-003 The module SHALL provide parameter VOTE_WINDOW, default 8, giving the cycles during which a second zone can confirm a first; it is used only when PIR_VOTE_EN is defined.

Interface
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 pir_sensor_1  input  1  zone 1 PIR output, asynchronous, active-high.
REQ-007 pir_sensor_2  input  1  zone 2 PIR output, asynchronous, active-high.
REQ-008 pir_sensor_3  input  1  zone 3 PIR output, asynchronous, active-high.
REQ-009 stop_alarm  input  1  synchronous disarm request, active-high.
REQ-010 motion_event  output  1  single-cycle pulse marking a qualified motion event.
REQ-011 zone_mask  output  3  zones contributing to the last event; bit0 = zone 1.
REQ-012 zone_active  output  3  per-zone qualified level, registered.

Function
REQ-013 Each pir_sensor_N SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-014 Each zone SHALL run an FSM with states IDLE, COUNT, ACTIVE, HOLDOFF.
- IDLE -> COUNT when the synchronized input is high.
- COUNT -> ACTIVE when the debounce counter reaches DEBOUNCE_CYCLES.
- COUNT -> IDLE on any synchronized low; the counter clears.
REQ-015 ACTIVE SHALL drive zone_active[N] high; ACTIVE -> HOLDOFF on the cycle the zone is consumed by an event; ACTIVE -> IDLE on synchronized low if the zone was not consumed.
REQ-016 HOLDOFF SHALL count HOLDOFF_CYCLES, then go to IDLE.
- The sensor input is ignored throughout HOLDOFF.
- A sensor still high at HOLDOFF expiry SHALL re-enter COUNT on the next cycle.
REQ-017 The debounce counter SHALL saturate at DEBOUNCE_CYCLES and the holdoff counter SHALL stop at zero; neither SHALL wrap.
REQ-018 Latency: with no vote and no holdoff, motion_event SHALL assert exactly DEBOUNCE_CYCLES+3 cycles after the first rising edge that samples pir_sensor_N high (5 cycles at default).
REQ-019 motion_event SHALL be high for exactly one cycle per event; zone_mask SHALL update on that same cycle and hold until the next event.
REQ-020 Zones qualifying on the same cycle SHALL produce one event, with all of them set in zone_mask and all of them entering HOLDOFF.
REQ-021 While stop_alarm is high, every zone SHALL be forced to IDLE with counters cleared, and motion_event SHALL stay low.
- zone_mask SHALL hold its value.
- Qualification SHALL restart from scratch after stop_alarm falls.
REQ-022 If stop_alarm and a qualification occur on the same cycle, stop_alarm SHALL win and no event is issued.

Reset
REQ-023 While rst_n is low at a rising clk edge, the following SHALL be cleared:
- synchronizer flops;
- all FSMs to IDLE;
- all counters to 0;
- motion_event = 0, zone_mask = 3'b000, zone_active = 3'b000.
REQ-024 Reset asserted mid-COUNT, mid-HOLDOFF or mid-vote-window SHALL discard all progress, with no event on the cycle after release.

Configuration
REQ-025 With macro PIR_VOTE_EN defined, an event SHALL require at least two zones ACTIVE within VOTE_WINDOW cycles.
- The first qualifying zone opens the window.
- The event fires on the cycle the second zone qualifies, with zone_mask = all zones ACTIVE at that cycle.
- Window expiry without a second zone SHALL close the window, and the first zone SHALL remain ACTIVE without an event.
- A second zone qualifying on the last window cycle SHALL still fire the event.
REQ-026 Without PIR_VOTE_EN, any single zone reaching ACTIVE SHALL fire an event; the vote-window logic SHALL be absent.

Verification
REQ-027 Default parameters, no vote: pir_sensor_1 high for 4 cycles -> motion_event pulses once, 5 cycles after the first sample; zone_mask = 3'b001.
REQ-028 pir_sensor_2 high for 1 cycle (shorter than DEBOUNCE_CYCLES) -> no motion_event, and zone_active stays 3'b000.
REQ-029 pir_sensor_1 and pir_sensor_3 rise on the same edge -> one pulse with zone_mask = 3'b101; pir_sensor_1 re-pulsed within 16 cycles -> no event.
REQ-030 stop_alarm high on the cycle zone 1 would qualify -> no event; stop_alarm low with pir_sensor_1 still high -> event 5 cycles later.
REQ-031 PIR_VOTE_EN defined: zone 1 qualifies, zone 2 qualifies 8 cycles later -> event with zone_mask = 3'b011; zone 2 at 9 cycles later -> no event.
REQ-032 rst_n low for 1 cycle during zone 3 HOLDOFF -> all outputs 0; pir_sensor_3 high -> event 5 cycles after release.
